// File: rtl/h2f_csr_pkg.sv
// Shared types and helpers for the H2F control/status register bank.
package h2f_csr_pkg;

  typedef enum logic [1:0] {
    REG_RW    = 2'd0,
    REG_RO    = 2'd1,
    REG_W1C   = 2'd2,
    REG_PULSE = 2'd3
  } reg_mode_e;

  localparam int unsigned OOR_CNT_W = 16;
  localparam int unsigned MAX_DW    = 64;
  localparam int unsigned MAX_BE    = MAX_DW / 8;

  // Expand byte-lane enables to a bit mask, sized for the widest bus.
  function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int b = 0; b < int'(MAX_BE); b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  // Replace only the enabled byte lanes of old_val with new_val.
  function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0] old_val,
                                                   input logic [MAX_DW-1:0] new_val,
                                                   input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] m;
    m = lane_mask(be);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/h2f_csr_reg.sv
// One CSR with its access mode, byte-lane handling and HPS/fabric collision rules.
module h2f_csr_reg
  import h2f_csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter reg_mode_e   MODE       = REG_RW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hps_wr,
  input  logic [DATA_WIDTH-1:0]   hps_data,
  input  logic [DATA_WIDTH/8-1:0] hps_be,
  input  logic                    fab_wr,
  input  logic [DATA_WIDTH-1:0]   fab_data,
  output logic [DATA_WIDTH-1:0]   q
);

  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] q_next;

  assign mask   = DATA_WIDTH'(lane_mask(MAX_BE'(hps_be)));
  assign merged = DATA_WIDTH'(lane_merge(MAX_DW'(q), MAX_DW'(hps_data), MAX_BE'(hps_be)));

  // HPS wins on RW/PULSE, fabric always applies on RO, W1C set beats clear per bit.
  always_comb begin
    q_next = q;
    case (MODE)
      REG_RW: begin
        if (hps_wr)      q_next = merged;
        else if (fab_wr) q_next = fab_data;
      end
      REG_RO: begin
        if (fab_wr) q_next = fab_data;
      end
      REG_W1C: begin
        q_next = (q & ~(hps_wr ? (hps_data & mask) : '0)) | (fab_wr ? fab_data : '0);
      end
      REG_PULSE: begin
        q_next = '0;
        if (hps_wr)      q_next = hps_data & mask;
        else if (fab_wr) q_next = fab_data;
      end
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule

// File: rtl/h2f_csr_bank.sv
// HPS-to-FPGA CSR bank: Avalon-MM slave with pipelined reads, per-register modes,
// fabric write port, W1C-derived interrupt and out-of-range access counter.
module h2f_csr_bank
  import h2f_csr_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 10,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           NUM_REGS     = 32,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [2*NUM_REGS-1:0] REG_MODES    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           read,
  input  logic                           write,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic [DATA_WIDTH-1:0]          writedata,
  input  logic [DATA_WIDTH/8-1:0]        byteenable,
  output logic [DATA_WIDTH-1:0]          readdata,
  output logic                           readdatavalid,
  output logic                           waitrequest,
  input  logic                           fabric_wr_i,
  input  logic [$clog2(NUM_REGS)-1:0]    fabric_sel_i,
  input  logic [DATA_WIDTH-1:0]          fabric_data_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic                           irq_o,
  output logic [OOR_CNT_W-1:0]           oor_count_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned LSB   = $clog2(DATA_WIDTH / 8);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("h2f_csr_bank: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 2 || NUM_REGS > 256) begin : g_bad_regs
    $error("h2f_csr_bank: NUM_REGS must be 2..256");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("h2f_csr_bank: READ_LATENCY must be 1..4");
  end

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      sel;
  logic                  in_range;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  oor_c;
  logic                  boot_q;
  logic                  wait_q;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   w1c_bits;
  logic                  irq_q;
  logic [OOR_CNT_W-1:0]  oor_q;
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

  assign word_idx = address >> LSB;
  assign sel      = word_idx[IDX_W-1:0];
  assign in_range = 32'(word_idx) < NUM_REGS;

  // A simultaneous read is dropped when a write is presented.
  assign wr_acc = !wait_q && write;
  assign rd_acc = !wait_q && read && !write;
  assign oor_c  = !wait_q && (read || write) && !in_range;

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    localparam reg_mode_e MODE = reg_mode_e'(REG_MODES[2*i +: 2]);

    h2f_csr_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODE       (MODE)
    ) u_reg (
      .clk      (clk),
      .rst      (rst),
      .hps_wr   (wr_acc && in_range && (sel == IDX_W'(i))),
      .hps_data (writedata),
      .hps_be   (byteenable),
      .fab_wr   (fabric_wr_i && (fabric_sel_i == IDX_W'(i))),
      .fab_data (fabric_data_i),
      .q        (regs_q[i])
    );

    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    assign w1c_bits[i] = (MODE == REG_W1C) && (|regs_q[i]);
  end

  assign rd_data_c = in_range ? regs_q[sel] : '0;

  // Stall through reset and for one cycle after it is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_q <= 1'b1;
      wait_q <= 1'b1;
    end else begin
      boot_q <= 1'b0;
      wait_q <= boot_q;
    end
  end

  // Read response pipeline; data held at zero on empty slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < int'(READ_LATENCY); k++) dat_q[k] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      dat_q[0] <= rd_acc ? rd_data_c : '0;
      for (int k = 1; k < int'(READ_LATENCY); k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
      oor_q <= '0;
    end else begin
      irq_q <= |w1c_bits;
      if (oor_c && (oor_q != '1)) oor_q <= oor_q + OOR_CNT_W'(1);
    end
  end

  assign readdata      = dat_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign waitrequest   = wait_q;
  assign irq_o         = irq_q;
  assign oor_count_o   = oor_q;

endmodule

// File: tb/tb_h2f_csr_bank.sv
// Directed, table-driven bench for h2f_csr_bank (32 regs x 32 bits, read latency 3).
module tb_h2f_csr_bank;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned RL = 3;
  // reg 10 W1C, reg 11 RO, reg 12 PULSE, rest RW
  localparam logic [2*NR-1:0] MODES = (64'd2 << 20) | (64'd1 << 22) | (64'd3 << 24);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic read = 1'b0;
  logic write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW/8-1:0] byteenable = '1;
  logic [DW-1:0] readdata;
  logic readdatavalid;
  logic waitrequest;
  logic fabric_wr_i = 1'b0;
  logic [4:0] fabric_sel_i = '0;
  logic [DW-1:0] fabric_data_i = '0;
  logic [NR*DW-1:0] regs_o;
  logic irq_o;
  logic [15:0] oor_count_o;

  int checks = 0;
  int errors = 0;

  h2f_csr_bank #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR),
    .READ_LATENCY (RL), .REG_MODES (MODES)
  ) dut (
    .clk (clk), .rst (rst), .read (read), .write (write), .address (address),
    .writedata (writedata), .byteenable (byteenable), .readdata (readdata),
    .readdatavalid (readdatavalid), .waitrequest (waitrequest),
    .fabric_wr_i (fabric_wr_i), .fabric_sel_i (fabric_sel_i),
    .fabric_data_i (fabric_data_i), .regs_o (regs_o), .irq_o (irq_o),
    .oor_count_o (oor_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hwr;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [3:0]    be;
    logic          fwr;
    logic [4:0]    fsel;
    logic [31:0]   fd;
    int            rg;
    logic [31:0]   now_v;
    logic [31:0]   aft_v;
    logic          irq;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return regs_o[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read = 1'b0; write = 1'b0; fabric_wr_i = 1'b0; byteenable = '1;
  endtask

  initial begin
    logic prev_irq;
    logic [31:0] exp_d;
    int k;

    vecs[0]  = '{1'b1, 10'h014, 32'h11223344, 4'hF, 1'b0, 5'd0,  32'h0,        5,  32'h11223344, 32'h11223344, 1'b0};
    vecs[1]  = '{1'b1, 10'h014, 32'hAABBCCDD, 4'h5, 1'b0, 5'd0,  32'h0,        5,  32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[2]  = '{1'b0, 10'h000, 32'h0,        4'hF, 1'b1, 5'd5,  32'h12345678, 5,  32'h12345678, 32'h12345678, 1'b0};
    vecs[3]  = '{1'b1, 10'h014, 32'h0,        4'hF, 1'b1, 5'd5,  32'h0000FFFF, 5,  32'h0,        32'h0,        1'b0};
    vecs[4]  = '{1'b1, 10'h028, 32'hFF,       4'hF, 1'b0, 5'd0,  32'h0,        10, 32'h0,        32'h0,        1'b0};
    vecs[5]  = '{1'b0, 10'h000, 32'h0,        4'hF, 1'b1, 5'd10, 32'h0F,       10, 32'h0F,       32'h0F,       1'b1};
    vecs[6]  = '{1'b1, 10'h028, 32'h03,       4'hF, 1'b1, 5'd10, 32'h01,       10, 32'h0D,       32'h0D,       1'b1};
    vecs[7]  = '{1'b1, 10'h028, 32'h0D,       4'hF, 1'b0, 5'd0,  32'h0,        10, 32'h0,        32'h0,        1'b0};
    vecs[8]  = '{1'b1, 10'h02C, 32'hFF,       4'hF, 1'b1, 5'd11, 32'h55,       11, 32'h55,       32'h55,       1'b0};
    vecs[9]  = '{1'b1, 10'h02C, 32'hFF,       4'hF, 1'b0, 5'd0,  32'h0,        11, 32'h55,       32'h55,       1'b0};
    vecs[10] = '{1'b1, 10'h030, 32'h8,        4'hF, 1'b0, 5'd0,  32'h0,        12, 32'h8,        32'h0,        1'b0};
    vecs[11] = '{1'b0, 10'h000, 32'h0,        4'hF, 1'b1, 5'd12, 32'h30,       12, 32'h30,       32'h0,        1'b0};
    vecs[12] = '{1'b1, 10'h084, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0,  32'h0,        1,  32'hA1,       32'hA1,       1'b0};
    vecs[13] = '{1'b1, 10'h00E, 32'hCAFE,     4'hF, 1'b0, 5'd0,  32'h0,        3,  32'hCAFE,     32'hCAFE,     1'b0};
    vecs[14] = '{1'b0, 10'h000, 32'h0,        4'hF, 1'b1, 5'd10, 32'hFF00FF00, 10, 32'hFF00FF00, 32'hFF00FF00, 1'b1};
    vecs[15] = '{1'b1, 10'h028, 32'hFFFFFFFF, 4'h2, 1'b0, 5'd0,  32'h0,        10, 32'hFF000000, 32'hFF000000, 1'b1};
    vecs[16] = '{1'b1, 10'h028, 32'hFF000000, 4'h8, 1'b0, 5'd0,  32'h0,        10, 32'h0,        32'h0,        1'b0};

    // Reset values, then waitrequest held one cycle past reset release.
    tick();
    chk("rst_wait", 64'(waitrequest), 64'd1);
    chk("rst_rdv", 64'(readdatavalid), 64'd0);
    chk("rst_rdata", 64'(readdata), 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_oor", 64'(oor_count_o), 64'd0);
    chk("rst_regs", 64'(regs_o == '0), 64'd1);
    rst = 1'b0;
    tick();
    chk("wait_after_rst", 64'(waitrequest), 64'd1);
    tick();
    chk("wait_drop", 64'(waitrequest), 64'd0);

    // Preload regs 0..3 with back-to-back writes.
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; address = AW'(i * 4); writedata = 32'hA0 + 32'(i);
      tick();
    end
    idle_inputs();

    // Four back-to-back reads; responses in four consecutive cycles after RL.
    for (int c = 0; c < 9; c++) begin
      read = (c < 4); address = AW'(c * 4);
      tick();
      k = c + 1 - int'(RL);
      chk($sformatf("b2b_rdv_c%0d", c), 64'(readdatavalid), 64'(k >= 0 && k < 4));
      exp_d = (k >= 0 && k < 4) ? 32'hA0 + 32'(k) : 32'h0;
      chk($sformatf("b2b_data_c%0d", c), 64'(readdata), 64'(exp_d));
    end

    // Out-of-range read returns zero with normal timing and counts once.
    read = 1'b1; address = 10'h080;
    tick();
    idle_inputs();
    for (int c = 1; c <= int'(RL); c++) begin
      chk($sformatf("oor_rdv_k%0d", c), 64'(readdatavalid), 64'(c == int'(RL)));
      chk($sformatf("oor_data_k%0d", c), 64'(readdata), 64'd0);
      if (c < int'(RL)) tick();
    end
    chk("oor_cnt1", 64'(oor_count_o), 64'd1);

    // Read in the cycle right after a write sees the new value.
    write = 1'b1; address = 10'h010; writedata = 32'h44;
    tick();
    write = 1'b0; read = 1'b1;
    tick();
    read = 1'b0;
    for (int c = 1; c <= int'(RL) + 1; c++) begin
      chk($sformatf("raw_rdv_k%0d", c), 64'(readdatavalid), 64'(c == int'(RL)));
      chk($sformatf("raw_data_k%0d", c), 64'(readdata), (c == int'(RL)) ? 64'h44 : 64'h0);
      tick();
    end

    // Read and write together: write lands, no read response.
    read = 1'b1; write = 1'b1; address = 10'h024; writedata = 32'h99;
    tick();
    idle_inputs();
    for (int c = 1; c <= int'(RL) + 1; c++) begin
      chk($sformatf("rw_rdv_k%0d", c), 64'(readdatavalid), 64'd0);
      tick();
    end
    chk("rw_reg9", 64'(reg_at(9)), 64'h99);

    // Mode, byte-lane and collision vectors.
    prev_irq = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write = vecs[i].hwr; address = vecs[i].addr; writedata = vecs[i].wd;
      byteenable = vecs[i].be; fabric_wr_i = vecs[i].fwr;
      fabric_sel_i = vecs[i].fsel; fabric_data_i = vecs[i].fd;
      tick();
      idle_inputs();
      chk($sformatf("vec%0d_now", i), 64'(reg_at(vecs[i].rg)), 64'(vecs[i].now_v));
      chk($sformatf("vec%0d_irq_now", i), 64'(irq_o), 64'(prev_irq));
      tick();
      chk($sformatf("vec%0d_after", i), 64'(reg_at(vecs[i].rg)), 64'(vecs[i].aft_v));
      chk($sformatf("vec%0d_irq", i), 64'(irq_o), 64'(vecs[i].irq));
      prev_irq = vecs[i].irq;
    end
    chk("oor_cnt2", 64'(oor_count_o), 64'd2);

    // Saturating out-of-range counter.
    write = 1'b1; address = 10'h100; writedata = 32'h0;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    write = 1'b0;
    tick();
    chk("oor_sat", 64'(oor_count_o), 64'hFFFF);

    // Reset one cycle after a read flushes it.
    read = 1'b1; address = 10'h000;
    tick();
    read = 1'b0; rst = 1'b1;
    tick();
    chk("mid_wait", 64'(waitrequest), 64'd1);
    chk("mid_rdv", 64'(readdatavalid), 64'd0);
    chk("mid_rdata", 64'(readdata), 64'd0);
    chk("mid_irq", 64'(irq_o), 64'd0);
    chk("mid_oor", 64'(oor_count_o), 64'd0);
    chk("mid_regs", 64'(regs_o == '0), 64'd1);
    rst = 1'b0;
    tick();
    chk("mid_wait_after", 64'(waitrequest), 64'd1);
    chk("mid_rdv_after", 64'(readdatavalid), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_flush_k%0d", c), 64'(readdatavalid), 64'd0);
    end
    chk("mid_wait_drop", 64'(waitrequest), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
